mux_scan_sel: RTL and testbench
===============================

Name: mux_scan_sel

Overview:
- Registered N-channel, W-bit multiplexer with a manual-select mode and an auto-scan mode.
- In auto-scan, an internal channel pointer steps through the inputs, dwelling a programmable number of cycles on each.
- Successor to the fixed 4-to-1, 1-bit combinational mux. Used as a sampled front-end selector feeding display and compare logic.

Parameters:
- WIDTH, 4, bits per channel (>=1).
- CHANNELS, 4, number of input channels (>=2; need not be a power of 2).
- DWELL, 1, cycles spent on each channel in auto-scan (>=1).
- SEL_W, $clog2(CHANNELS), derived select width; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- din  in  CHANNELS*WIDTH  flattened inputs; channel k = din[k*WIDTH +: WIDTH].
- sel  in  SEL_W  manual channel select.
- auto_en  in  1  1 = auto-scan mode, 0 = manual mode.
- hold  in  1  freezes the block.
- dout  out  WIDTH  registered selected data.
- dout_ch  out  SEL_W  channel index that produced dout.
- dout_valid  out  1  dout updated with a new sample this cycle.
- wrap  out  1  one-cycle pulse when the scan pointer wraps CHANNELS-1 -> 0.

Behaviour:
- Interface (already decided): one clock, clk; reset resetn is asynchronous and active-low. All state is updated on the rising edge of clk.
- Reset (resetn=0, asynchronous): dout=0, dout_ch=0, dout_valid=0, wrap=0, ptr=0, dwell_cnt=0, state=MANUAL. The first edge after release behaves as a normal MANUAL/SCAN cycle.
- States and transitions, evaluated each edge, priority top-down:
  - hold=1: stay in the current state. ptr, dwell_cnt, dout and dout_ch are frozen; dout_valid=0, wrap=0.
  - MANUAL and auto_en=1: go to SCAN with ptr=0, dwell_cnt=0. That same edge already samples channel 0.
  - SCAN and auto_en=0: go to MANUAL with ptr=0. That edge is a manual sample.
- MANUAL sample, latency 1 cycle:
  - sel < CHANNELS: dout<=din[sel], dout_ch<=sel, dout_valid<=1.
  - sel >= CHANNELS: dout and dout_ch hold, dout_valid<=0.
- SCAN sample:
  - Each cycle: dout<=din[ptr], dout_ch<=ptr, so the data tracks the current input.
  - dout_valid<=1 only on the first cycle of each dwell (dwell_cnt==0); with DWELL=1 it is 1 every cycle.
  - dwell_cnt==DWELL-1: dwell_cnt<=0 and ptr advances. ptr==CHANNELS-1 -> ptr<=0 and wrap<=1; otherwise ptr<=ptr+1.
  - Otherwise dwell_cnt increments.
- wrap is registered and coincides with the dout sample of the last channel's final dwell cycle.
- Counter widths: ptr is SEL_W bits; dwell_cnt is max(1,$clog2(DWELL)) bits. Neither counter ever exceeds its limit.
- hold asserted mid-dwell: the dwell resumes where it stopped once hold deasserts. The remaining count is preserved and dout_valid is not re-asserted.
- Reset mid-scan: immediate return to reset values; no wrap pulse.

Optional Feature:
- Macro: MUX_SCAN_MASK_EN.
- Defined:
  - Adds input port chan_mask [CHANNELS-1:0].
  - SCAN advances ptr to the next channel with mask=1, searching cyclically. wrap fires when the search passes index CHANNELS-1.
  - chan_mask all zero: ptr holds and dout_valid=0.
  - On MANUAL->SCAN entry, ptr goes to the lowest unmasked channel.
  - MANUAL mode ignores the mask.
- Undefined: no port; all channels are scanned.

Decomposition:
- Package mux_scan_pkg holds:
  - state encoding (MANUAL=1'b0, SCAN=1'b1);
  - default parameter constants;
  - the function next_unmasked(mask, ptr) used when the macro is set.
- Natural sub-module: mux_nto1.
  - Purely combinational, parametrised WIDTH/CHANNELS.
  - Selects din channel by index and returns 0 for an out-of-range index.
  - mux_scan_sel instantiates it once for the data path and registers its output.

Test Plan:
- Reset: CHANNELS=4, WIDTH=4, din={4'hD,4'hC,4'hB,4'hA}. Pulse resetn low mid-cycle -> all outputs 0 immediately, asynchronously.
- Manual mode, same din: sel=2 -> dout=4'hC, dout_ch=2, dout_valid=1 one edge later. CHANNELS=5, sel=7 -> dout holds, dout_valid=0.
- Auto-scan, DWELL=1: auto_en=1 -> dout sequence A,B,C,D,A; wrap=1 on the D cycle only.
- Auto-scan, DWELL=3: each channel is held 3 cycles with dout_valid only on the first; CHANNELS=3 -> wrap period 9 cycles.
- hold=1 for 5 cycles on channel 1, second dwell cycle -> outputs frozen, dout_valid=0. After release: 1 more cycle on channel 1, then channel 2.
- MUX_SCAN_MASK_EN, chan_mask=4'b1010 -> scan order 1,3,1,3 with wrap after each 3. chan_mask=0 -> dout_valid stays 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding, default parameters and the
// cyclic mask-search helper for the mux_scan_sel block.
package mux_scan_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_e;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DWELL    = 1;
    localparam int MAX_CHANNELS = 32;
    localparam int MAX_IDX_W    = $clog2(MAX_CHANNELS);

    // Next set bit after ptr, searching cyclically over n channels;
    // returns ptr itself when no other channel is set.
    function automatic int next_unmasked(
        input logic [MAX_CHANNELS-1:0] mask,
        input int                      ptr,
        input int                      n
    );
        int   idx;
        logic found;
        next_unmasked = ptr;
        found         = 1'b0;
        for (int i = 1; i <= MAX_CHANNELS; i++) begin
            if (!found && i <= n) begin
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (mask[idx[MAX_IDX_W-1:0]]) begin
                    next_unmasked = idx;
                    found         = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// mux_nto1: combinational N-to-1 selector over a flattened bus;
// an index beyond the last channel yields zero.
module mux_nto1 #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          idx,
    output logic [WIDTH-1:0]          dout
);

    always_comb begin
        dout = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                dout = din[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-channel mux, manual select or auto-scan with dwell.
// Build option MUX_SCAN_MASK_EN adds chan_mask to skip channels while scanning.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DWELL    = DEF_DWELL,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      auto_en,
    input  logic                      hold,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CHANNELS-1:0]       chan_mask,
`endif
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          dout_ch,
    output logic                      dout_valid,
    output logic                      wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   CH_NUM   = (SEL_W + 1)'(CHANNELS);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_d;
    logic [SEL_W-1:0] ch_d;
    logic             valid_d;
    logic             wrap_d;

    logic             go_hold, go_entry, go_scan, go_man;
    logic [SEL_W-1:0] scan_ptr, first_ptr, nxt_ptr, mux_idx;
    logic [CNT_W-1:0] scan_cnt;
    logic             nxt_wrap, mask_none, sel_ok;
    logic [WIDTH-1:0] mux_y;

    // Entry into scan behaves as the first dwell cycle of the first channel.
    always_comb begin
        go_hold  = hold;
        go_entry = !hold && auto_en && (state_q == MANUAL);
        go_scan  = !hold && auto_en && (state_q == SCAN);
        go_man   = !hold && !auto_en;
        scan_ptr = go_entry ? first_ptr : ptr_q;
        scan_cnt = go_entry ? '0 : cnt_q;
        mux_idx  = (go_entry || go_scan) ? scan_ptr : sel;
    end

`ifdef MUX_SCAN_MASK_EN
    logic [MAX_CHANNELS-1:0] mask_ext;

    always_comb begin
        mask_ext                 = '0;
        mask_ext[CHANNELS-1:0]   = chan_mask;
    end

    assign mask_none = (chan_mask == '0);
    assign first_ptr = mask_none ? '0 :
        SEL_W'(next_unmasked(mask_ext, CHANNELS - 1, CHANNELS));
    assign nxt_ptr   = SEL_W'(next_unmasked(mask_ext, int'(scan_ptr), CHANNELS));
    assign nxt_wrap  = (nxt_ptr <= scan_ptr);
`else
    assign mask_none = 1'b0;
    assign first_ptr = '0;
    assign nxt_wrap  = (scan_ptr == PTR_LAST);
    assign nxt_ptr   = nxt_wrap ? '0 : scan_ptr + 1'b1;
`endif

    mux_nto1 #(
        .WIDTH   (WIDTH),
        .CHANNELS(CHANNELS),
        .SEL_W   (SEL_W)
    ) u_mux (
        .din (din),
        .idx (mux_idx),
        .dout(mux_y)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout;
        ch_d    = dout_ch;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        sel_ok  = ({1'b0, sel} < CH_NUM);
        unique case (1'b1)
            go_hold: begin
            end
            go_entry, go_scan: begin
                state_d = SCAN;
                ptr_d   = scan_ptr;
                cnt_d   = scan_cnt;
                if (!mask_none) begin
                    dout_d  = mux_y;
                    ch_d    = scan_ptr;
                    valid_d = (scan_cnt == '0);
                    if (scan_cnt == CNT_LAST) begin
                        cnt_d  = '0;
                        ptr_d  = nxt_ptr;
                        wrap_d = nxt_wrap;
                    end else begin
                        cnt_d = scan_cnt + 1'b1;
                    end
                end
            end
            go_man: begin
                state_d = MANUAL;
                ptr_d   = '0;
                cnt_d   = '0;
                if (sel_ok) begin
                    dout_d  = mux_y;
                    ch_d    = sel;
                    valid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= MANUAL;
            ptr_q      <= '0;
            cnt_q      <= '0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dout       <= dout_d;
            dout_ch    <= ch_d;
            dout_valid <= valid_d;
            wrap       <= wrap_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// tb_mux_scan_sel: directed vectors over three mux_scan_sel configurations.
// Expected values are hand-computed from the channel data below.
module tb_mux_scan_sel;

    typedef struct {
        int         d;
        logic [2:0] sel;
        logic       a;
        logic       h;
        logic [7:0] o;
        logic [7:0] c;
        logic       vl;
        logic       w;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] din4 = {4'hD, 4'hC, 4'hB, 4'hA};
    logic [19:0] din5 = {4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
    logic [11:0] din3 = {4'h3, 4'h2, 4'h1};
    logic [1:0]  sel4, sel3;
    logic [2:0]  sel5;
    logic        auto4, auto5, auto3;
    logic        hold4, hold5, hold3;
    logic [3:0]  dout4, dout5, dout3;
    logic [1:0]  ch4, ch3;
    logic [2:0]  ch5;
    logic        v4, v5, v3, w4, w5, w3;
`ifdef MUX_SCAN_MASK_EN
    logic [3:0]  mask4 = 4'hF;
    logic [4:0]  mask5 = 5'h1F;
    logic [2:0]  mask3 = 3'h7;
`endif

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mux_scan_sel #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u4 (
        .clk(clk), .resetn(resetn), .din(din4), .sel(sel4),
        .auto_en(auto4), .hold(hold4),
`ifdef MUX_SCAN_MASK_EN
        .chan_mask(mask4),
`endif
        .dout(dout4), .dout_ch(ch4), .dout_valid(v4), .wrap(w4)
    );

    mux_scan_sel #(.WIDTH(4), .CHANNELS(5), .DWELL(1)) u5 (
        .clk(clk), .resetn(resetn), .din(din5), .sel(sel5),
        .auto_en(auto5), .hold(hold5),
`ifdef MUX_SCAN_MASK_EN
        .chan_mask(mask5),
`endif
        .dout(dout5), .dout_ch(ch5), .dout_valid(v5), .wrap(w5)
    );

    mux_scan_sel #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u3 (
        .clk(clk), .resetn(resetn), .din(din3), .sel(sel3),
        .auto_en(auto3), .hold(hold3),
`ifdef MUX_SCAN_MASK_EN
        .chan_mask(mask3),
`endif
        .dout(dout3), .dout_ch(ch3), .dout_valid(v3), .wrap(w3)
    );

    function automatic vec_t v(int d, int s, bit a, bit h,
                               int o, int c, bit vl, bit w);
        vec_t r;
        r.d   = d;
        r.sel = 3'(s);
        r.a   = a;
        r.h   = h;
        r.o   = 8'(o);
        r.c   = 8'(c);
        r.vl  = vl;
        r.w   = w;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic read_dut(input int d, output logic [7:0] o,
                            output logic [7:0] c, output logic vl,
                            output logic w);
        case (d)
            0: begin o = 8'(dout4); c = 8'(ch4); vl = v4; w = w4; end
            1: begin o = 8'(dout5); c = 8'(ch5); vl = v5; w = w5; end
            default: begin o = 8'(dout3); c = 8'(ch3); vl = v3; w = w3; end
        endcase
    endtask

    task automatic check_dut(input string nm, input int d, input int o,
                             input int c, input bit vl, input bit w);
        logic [7:0] ao, ac;
        logic       avl, aw;
        read_dut(d, ao, ac, avl, aw);
        chk({nm, " dout"}, ao, 8'(o));
        chk({nm, " ch"}, ac, 8'(c));
        chk({nm, " valid"}, 8'(avl), 8'(vl));
        chk({nm, " wrap"}, 8'(aw), 8'(w));
    endtask

    task automatic drive(input vec_t t);
        hold4 = 1'b1;
        hold5 = 1'b1;
        hold3 = 1'b1;
        case (t.d)
            0: begin sel4 = t.sel[1:0]; auto4 = t.a; hold4 = t.h; end
            1: begin sel5 = t.sel; auto5 = t.a; hold5 = t.h; end
            default: begin sel3 = t.sel[1:0]; auto3 = t.a; hold3 = t.h; end
        endcase
    endtask

    initial begin
        resetn = 1'b0;
        sel4 = '0; sel5 = '0; sel3 = '0;
        auto4 = 1'b0; auto5 = 1'b0; auto3 = 1'b0;
        hold4 = 1'b1; hold5 = 1'b1; hold3 = 1'b1;

        // u4 manual, then scan with DWELL=1
        tbl.push_back(v(0, 2, 0, 0, 'hC, 2, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 'hA, 0, 1, 0));
        tbl.push_back(v(0, 3, 0, 0, 'hD, 3, 1, 0));
        tbl.push_back(v(0, 1, 0, 1, 'hD, 3, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 'hA, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 'hB, 1, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 'hC, 2, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 'hD, 3, 1, 1));
        tbl.push_back(v(0, 0, 1, 0, 'hA, 0, 1, 0));
        tbl.push_back(v(0, 0, 1, 1, 'hA, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 'hB, 1, 1, 0));
        tbl.push_back(v(0, 3, 0, 0, 'hD, 3, 1, 0));
        tbl.push_back(v(0, 0, 1, 0, 'hA, 0, 1, 0));
        // u5 out-of-range manual select
        tbl.push_back(v(1, 4, 0, 0, 5, 4, 1, 0));
        tbl.push_back(v(1, 7, 0, 0, 5, 4, 0, 0));
        tbl.push_back(v(1, 5, 0, 0, 5, 4, 0, 0));
        tbl.push_back(v(1, 1, 0, 0, 2, 1, 1, 0));
        // u3 DWELL=3 scan with a 5-cycle hold mid-dwell on channel 1
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 2, 1, 1, 0));
        tbl.push_back(v(2, 0, 1, 0, 2, 1, 0, 0));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(v(2, 0, 1, 1, 2, 1, 0, 0));
        end
        tbl.push_back(v(2, 0, 1, 0, 2, 1, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 3, 2, 1, 0));
        tbl.push_back(v(2, 0, 1, 0, 3, 2, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 3, 2, 0, 1));
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 2, 1, 1, 0));
        tbl.push_back(v(2, 0, 1, 0, 2, 1, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 2, 1, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 3, 2, 1, 0));
        tbl.push_back(v(2, 0, 1, 0, 3, 2, 0, 0));
        tbl.push_back(v(2, 0, 1, 0, 3, 2, 0, 1));
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 1, 0));

        repeat (2) @(posedge clk);
        #1;
        check_dut("rst u4", 0, 0, 0, 0, 0);
        check_dut("rst u5", 1, 0, 0, 0, 0);
        check_dut("rst u3", 2, 0, 0, 0, 0);

        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_dut($sformatf("vec%0d", i), tbl[i].d, tbl[i].o,
                      tbl[i].c, tbl[i].vl, tbl[i].w);
        end

        // u4 resumes scan at channel 1, reaches D with wrap, then async reset
        @(negedge clk);
        drive(v(0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check_dut("seq B", 0, 'hB, 1, 1, 0);
        @(posedge clk); #1;
        check_dut("seq C", 0, 'hC, 2, 1, 0);
        @(posedge clk); #1;
        check_dut("seq D", 0, 'hD, 3, 1, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_dut("async rst u4", 0, 0, 0, 0, 0);
        check_dut("async rst u3", 2, 0, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check_dut("post rst", 0, 'hA, 0, 1, 0);

`ifdef MUX_SCAN_MASK_EN
        @(negedge clk);
        drive(v(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check_dut("mask man", 0, 'hA, 0, 1, 0);
        @(negedge clk);
        mask4 = 4'b1010;
        drive(v(0, 0, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check_dut($sformatf("mask b%0d", k), 0, 'hB, 1, 1, 0);
            @(posedge clk); #1;
            check_dut($sformatf("mask d%0d", k), 0, 'hD, 3, 1, 1);
        end
        @(negedge clk);
        mask4 = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mask none v%0d", k), 8'(v4), 8'd0);
            chk($sformatf("mask none w%0d", k), 8'(w4), 8'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
